// File: rtl/mux_rr_arbiter.sv
// Four-requester round-robin arbiter with packet locking, feeding one shared
// registered output stage (1 beat/cycle with backpressure).
module mux_rr_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           in_valid,
    input  logic [4*WIDTH-1:0]   in_data,
    input  logic [3:0]           in_last,
    output logic [3:0]           in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    output logic [1:0]           out_src,
    input  logic                 out_ready
);

    localparam int unsigned N_REQ = 4;

    typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] owner;

    logic       load_ok;
    logic       gnt_valid;
    logic [1:0] gnt_idx;
    logic [1:0] cand;
    logic       xfer;
    logic [WIDTH-1:0] sel_data;
    logic       sel_last;

    assign load_ok = !out_valid || out_ready;

    // Grant selection: locked owner only, otherwise first valid from ptr upward
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = 2'd0;
        cand      = 2'd0;
        if (state == LOCK) begin
            gnt_valid = in_valid[owner];
            gnt_idx   = owner;
        end else begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                cand = ptr + 2'(i);
                if (!gnt_valid && in_valid[cand]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = cand;
                end
            end
        end
    end

    assign xfer     = gnt_valid && load_ok;
    assign in_ready = (xfer && rst_n) ? (4'b0001 << gnt_idx) : 4'b0000;
    assign sel_data = in_data[gnt_idx*WIDTH +: WIDTH];
    assign sel_last = in_last[gnt_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB;
            ptr       <= 2'd0;
            owner     <= 2'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= 2'd0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_last  <= sel_last;
            out_src   <= gnt_idx;
            if (state == ARB) begin
                if (sel_last) begin
                    ptr <= gnt_idx + 2'd1;
                end else begin
                    state <= LOCK;
                    owner <= gnt_idx;
                end
            end else if (sel_last) begin
                state <= ARB;
                ptr   <= owner + 2'd1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: vector table of per-cycle grants plus hand-written
// backpressure and mid-packet reset sequences; output beats checked via a queue.
module tb_mux_rr_arbiter;

    localparam int unsigned W = 8;

    logic             clk;
    logic             rst_n;
    logic [3:0]       in_valid;
    logic [4*W-1:0]   in_data;
    logic [3:0]       in_last;
    logic [3:0]       in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic             out_last;
    logic [1:0]       out_src;
    logic             out_ready;

    mux_rr_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] last;
        logic       oready;
        logic [3:0] exp_ready;
    } vec_t;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
        logic [1:0]   src;
    } beat_t;

    vec_t  vecs[$];
    beat_t sb[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    function automatic logic [1:0] oh_idx(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    // One cycle: drive at negedge, check outputs/in_ready, record expected beat
    task automatic step(input logic [3:0] v, input logic [3:0] l, input logic ordy,
                        input logic [3:0] exp_rdy, input bit a5, input string name);
        beat_t      b;
        beat_t      e;
        logic [1:0] k;
        @(negedge clk);
        in_valid  = v;
        in_last   = l;
        out_ready = ordy;
        in_data   = 32'($urandom);
        if (a5) in_data[W-1:0] = 8'hA5;
        #1;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check({name, " unexpected_beat"}, 32'(1), 32'(0));
            end else begin
                e = sb.pop_front();
                check({name, " out_data"}, 32'(out_data), 32'(e.data));
                check({name, " out_last"}, 32'(out_last), 32'(e.last));
                check({name, " out_src"},  32'(out_src),  32'(e.src));
            end
        end
        check({name, " in_ready"}, 32'(in_ready), 32'(exp_rdy));
        if (exp_rdy != 4'b0000) begin
            k      = oh_idx(exp_rdy);
            b.data = in_data[k*W +: W];
            b.last = l[k];
            b.src  = k;
            sb.push_back(b);
        end
    endtask

    function automatic void add(input logic [3:0] v, input logic [3:0] l,
                                input logic o, input logic [3:0] r);
        vec_t x;
        x.valid = v; x.last = l; x.oready = o; x.exp_ready = r;
        vecs.push_back(x);
    endfunction

    initial begin
        // rotation 0,1,2,3,0 at full rate
        add(4'b1111, 4'b1111, 1'b1, 4'b0001);
        add(4'b1111, 4'b1111, 1'b1, 4'b0010);
        add(4'b1111, 4'b1111, 1'b1, 4'b0100);
        add(4'b1111, 4'b1111, 1'b1, 4'b1000);
        add(4'b1111, 4'b1111, 1'b1, 4'b0001);
        add(4'b0000, 4'b1111, 1'b1, 4'b0000);
        // ptr=2 with only 0,1 valid
        add(4'b0010, 4'b1111, 1'b1, 4'b0010);
        add(4'b0011, 4'b1111, 1'b1, 4'b0001);
        add(4'b0011, 4'b1111, 1'b1, 4'b0010);
        // three-beat packet from 1 while others contend
        add(4'b0001, 4'b1111, 1'b1, 4'b0001);
        add(4'b1111, 4'b0000, 1'b1, 4'b0010);
        add(4'b1111, 4'b0000, 1'b1, 4'b0010);
        add(4'b1111, 4'b0010, 1'b1, 4'b0010);
        add(4'b1111, 4'b1111, 1'b1, 4'b0100);
        add(4'b0000, 4'b1111, 1'b1, 4'b0000);
        // lock on 3, owner idle for two cycles, then wrap to 0
        add(4'b1000, 4'b0000, 1'b1, 4'b1000);
        add(4'b0111, 4'b1111, 1'b1, 4'b0000);
        add(4'b0111, 4'b1111, 1'b1, 4'b0000);
        add(4'b1111, 4'b1000, 1'b1, 4'b1000);
        add(4'b1111, 4'b1111, 1'b1, 4'b0001);
        add(4'b0000, 4'b1111, 1'b1, 4'b0000);
        // short backpressure, then simultaneous in/out transfer
        add(4'b0100, 4'b1111, 1'b1, 4'b0100);
        add(4'b1111, 4'b1111, 1'b0, 4'b0000);
        add(4'b1111, 4'b1111, 1'b0, 4'b0000);
        add(4'b1111, 4'b1111, 1'b1, 4'b1000);
        add(4'b0000, 4'b1111, 1'b1, 4'b0000);

        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_last   = 4'b1111;
        in_data   = 32'hFFFF_FFFF;
        out_ready = 1'b1;
        #3;
        check("rst out_valid", 32'(out_valid), 32'(0));
        check("rst out_data",  32'(out_data),  32'(0));
        check("rst out_last",  32'(out_last),  32'(0));
        check("rst out_src",   32'(out_src),   32'(0));
        check("rst in_ready",  32'(in_ready),  32'(0));
        in_valid = 4'b0000;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vecs[i])
            step(vecs[i].valid, vecs[i].last, vecs[i].oready, vecs[i].exp_ready,
                 1'b0, $sformatf("vec%0d", i));

        // held beat A5 under 5 cycles of backpressure
        step(4'b0001, 4'b1111, 1'b0, 4'b0001, 1'b1, "a5_load");
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, $sformatf("hold%0d", i));
            check($sformatf("hold%0d out_data", i), 32'(out_data), 32'h0000_00A5);
            check($sformatf("hold%0d out_valid", i), 32'(out_valid), 32'(1));
        end
        step(4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b0, "a5_release");
        step(4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, "a5_drain");

        // reset pulse between edges while locked on requester 0
        step(4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b0, "lock0");
        @(negedge clk);
        in_valid = 4'b0000;
        #1 check("prerst out_valid", 32'(out_valid), 32'(1));
        #1 rst_n = 1'b0;
        #1;
        check("midrst out_valid", 32'(out_valid), 32'(0));
        check("midrst in_ready",  32'(in_ready),  32'(0));
        rst_n = 1'b1;
        sb.delete();
        step(4'b1000, 4'b1111, 1'b1, 4'b1000, 1'b0, "postrst3");
        step(4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0, "postrst_wrap");
        step(4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, "final_drain");
        @(negedge clk);
        #1;
        check("end out_valid", 32'(out_valid), 32'(0));
        check("end sb_empty",  32'(sb.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, data width of every channel.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 in_valid  input  4  per-requester valid; bit k belongs to requester k.
REQ-005 in_data  input  4*WIDTH  per-requester data; requester k occupies bits [k*WIDTH +: WIDTH].
REQ-006 in_last  input  4  per-requester end-of-packet flag, qualified by in_valid[k].
REQ-007 in_ready  output  4  per-requester accept; a beat from k transfers when in_valid[k] & in_ready[k].
REQ-008 out_valid  output  1  output register holds a beat.
REQ-009 out_data  output  WIDTH  registered data of the held beat.
REQ-010 out_last  output  1  registered last flag of the held beat.
REQ-011 out_src  output  2  index of the requester that supplied the held beat.
REQ-012 out_ready  input  1  downstream accept; the output transfers when out_valid & out_ready.

Function
REQ-013 The block SHALL share one output register among 4 requesters, selecting a source via a 4:1 data mux controlled by the grant index.
REQ-014 "load_ok" SHALL equal !out_valid | out_ready, meaning the output register can accept a beat this cycle.
REQ-015 in_ready SHALL be combinational, one-hot or zero, and nonzero only when load_ok is 1.
REQ-016 On a transfer from requester k, the output register SHALL load in_data[k], in_last[k] and src=k at the next edge, with out_valid=1; latency is 1 cycle.
REQ-017 When load_ok is 1, out_ready is 1 and no input transfer occurs, out_valid SHALL go to 0 at the next edge.
REQ-018 A simultaneous output transfer and input transfer SHALL both complete, giving 1 beat/cycle sustained throughput.
REQ-019 While out_valid=1 and out_ready=0, out_data, out_last and out_src SHALL stay stable, and in_ready SHALL be 0.
REQ-020 The block SHALL keep a 2-bit round-robin pointer ptr and an FSM with states ARB and LOCK, plus a 2-bit owner register.
REQ-021 In ARB, the grant SHALL go to the first k with in_valid[k]=1, searching in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-022 In ARB, a transfer with in_last=1 SHALL keep the state at ARB and set ptr = k+1 mod 4.
REQ-023 In ARB, a transfer with in_last=0 SHALL move the state to LOCK with owner=k; ptr SHALL be unchanged.
REQ-024 In LOCK, only the owner SHALL be granted; in_ready SHALL be 0 for other requesters, even when the owner's in_valid is 0.
REQ-025 In LOCK, an owner transfer with in_last=1 SHALL return the state to ARB and set ptr = owner+1 mod 4; with in_last=0 the state SHALL stay LOCK.
REQ-026 ptr increments SHALL wrap from 3 to 0.
REQ-027 With no in_valid bit set in ARB, the block SHALL grant nothing and leave ptr and the state unchanged.
REQ-028 in_data, in_last and in_valid of ungranted requesters SHALL have no effect on any state.

Reset
REQ-029 While rst_n=0, outputs SHALL be: out_valid=0, out_data=0, out_last=0, out_src=0; state SHALL be ARB, ptr=0, owner=0; in_ready SHALL be 0.
REQ-030 Reset SHALL take effect immediately on rst_n falling, without waiting for clk.
REQ-031 Reset asserted mid-packet (in LOCK) SHALL abandon the packet; after release, arbitration SHALL restart from ptr=0.
REQ-032 The first transfer after reset SHALL be possible on the first rising edge with rst_n=1.

Verification
REQ-033 Reset, then in_valid=4'b1111 with all last=1 and out_ready=1 held -> out_src sequence 0,1,2,3,0, one beat per cycle.
REQ-034 ptr=2, in_valid=4'b0011 with last=1 -> requester 0 granted first, then requester 1.
REQ-035 Requester 1 sends 3 beats (last on the 3rd) while requesters 0, 2 and 3 are valid -> out_src=1 for 3 consecutive beats, next grant to requester 2.
REQ-036 out_valid=1, out_data=8'hA5 and out_ready=0 for 5 cycles with all in_valid=1 -> in_ready=0 and out_data=8'hA5 throughout; the beat is accepted on the cycle out_ready rises.
REQ-037 LOCK on requester 3, owner in_valid drops for 2 cycles with others valid -> no grants, state stays LOCK; resumes when the owner is valid again.
REQ-038 rst_n pulsed low between clk edges while in LOCK -> out_valid=0 immediately; after release, in_valid=4'b1000 -> requester 3 granted, state ARB.
